cram_arbiter: RTL and testbench
===============================

# cram_arbiter

Shares the single cartridge-RAM SRAM port between three requesters: CPU cartridge-RAM traffic, the savestate CRAM port, and the backup (save-file) load/save port. It sits between the mapper/savestate logic and the SRAM controller's internal single-port bus. It provides these functions:
- serialises accesses with a req/ack handshake;
- steers bytes onto the 16-bit word bus;
- applies fixed priority with a CPU starvation guard;
- tracks whether the CPU has modified save RAM.

## Interface
Parameters:
- STARVE_LIMIT, 4: maximum consecutive CPU grants while another requester waits (1..15).

Ports:
- clk_sys  in  1  system clock, single clock domain.
- reset  in  1  synchronous, active-high reset.
- cpu_req / ss_req  in  1  access request; held until the matching ack.
- cpu_we / ss_we  in  1  1 = write, 0 = read; sampled at grant.
- cpu_addr / ss_addr  in  17  byte address.
- cpu_wdata / ss_wdata  in  8  write byte.
- cpu_ack / ss_ack  out  1  one-cycle completion pulse.
- cpu_rdata / ss_rdata  out  8  read byte; valid in the ack cycle and held until the next ack on that port.
- bk_req, bk_we  in  1  backup word request and direction.
- bk_addr  in  16  word address.
- bk_wdata  in  16  write word.
- bk_ack  out  1  completion pulse.
- bk_rdata  out  16  read word.
- mem_req  out  1  SRAM access request; held until mem_ack.
- mem_we, mem_ub, mem_lb  out  1  write enable and upper/lower byte enables.
- mem_addr  out  16  word address.
- mem_d  out  16  write data.
- mem_ack  in  1  SRAM completion pulse.
- mem_q  in  16  read data, valid with mem_ack.
- dirty  out  1  set by a completed CPU write.
- dirty_clr  in  1  clears dirty.

## Operation
- States: IDLE, WAIT, DONE.
- **IDLE:** if any req is high, choose a winner and latch its we, address and data. Then assert mem_req and go to WAIT.
- **Priority:** CPU > SS > BK.
- **Starvation guard:** a 4-bit streak counter increments on each CPU grant made while ss_req or bk_req is high. When streak == STARVE_LIMIT and ss_req or bk_req is high, the highest-priority non-CPU requester wins instead and streak clears. Streak also clears on any non-CPU grant, and on a CPU grant with no other request pending.
- **WAIT:** hold mem_* stable. On mem_ack, capture the read data, deassert mem_req, pulse the winner's ack and go to DONE.
- **DONE:** one cycle, then IDLE. No grant is made in DONE.
- **Byte ports (CPU, SS):**
  - mem_addr = addr[16:1].
  - mem_d = {wdata, wdata}.
  - Writes: mem_ub = addr[0], mem_lb = ~addr[0].
  - Reads: mem_ub = mem_lb = 1; rdata = addr[0] ? mem_q[15:8] : mem_q[7:0].
- **BK port:** word access. mem_ub = mem_lb = 1, mem_addr = bk_addr, bk_rdata = mem_q.
- **dirty:** set in the cpu_ack cycle of a write (registered, visible the next cycle). dirty_clr clears it. If set and clear coincide, set wins.
- **mem_ack outside WAIT** is ignored.
- **Requester rule:** req must be low in the cycle after ack unless a new access is intended. A req still high in IDLE is a new request.

## Timing
- **Reset values:** every output is 0, including rdata registers and dirty. State = IDLE, streak = 0.
- **Reset mid-access:** the access is abandoned, mem_req is low the next cycle, and no ack is issued.
- **Latency:** req is sampled high in IDLE at cycle 0.
  - mem_req is high from cycle 1.
  - mem_ack arrives in cycle 1+L, where L ≥ 0 is SRAM latency; L = 0 means mem_ack is already high in cycle 1.
  - The requester ack arrives in cycle 2+L.
  - The earliest next grant is cycle 3+L; back-to-back throughput is one access per 3+L cycles.
- **Ack and mem outputs:** all acks and mem_* outputs are registered; no combinational path from req to mem_*.
- **Simultaneous requests:** all three requesting at once are granted one at a time per the priority and starvation rules. No request is ever dropped.

## Structure
- Package cram_arb_pkg holds:
  - the state enum (IDLE/WAIT/DONE);
  - requester-id constants (ID_CPU = 0, ID_SS = 1, ID_BK = 2);
  - the streak counter width.
- Sub-module cram_arb_prio holds the winner selection plus the streak counter. Inputs are the three reqs and a grant strobe; output is the winner id. It is separately testable.
- Top level holds the FSM, latches, lane steering and dirty flag.

## Test plan
- **Reset defaults:** reset for 2 cycles -> all outputs 0; dirty = 0.
- **CPU byte write:** cpu_req with we = 1, addr = 0x00005, wdata = 0xA5, L = 2 -> mem_req cycles 1-3; mem_addr = 0x0002, mem_d = 0xA5A5, ub = 1, lb = 0; cpu_ack in cycle 4; dirty = 1 in cycle 5.
- **SS byte read:** ss read at addr 0x00004 with mem_q = 0x1234 -> ss_rdata = 0x34; at addr 0x00005 -> ss_rdata = 0x12.
- **Starvation guard:** STARVE_LIMIT = 4; cpu_req re-asserted continuously with bk_req high -> grant order CPU, CPU, CPU, CPU, BK, CPU...
- **Three-way collision:** cpu, ss and bk requests in the same cycle -> grant order CPU, SS, BK; exactly one ack each; bk_rdata equals mem_q.
- **Reset mid-access and dirty collision:** reset asserted in WAIT -> mem_req low the next cycle and no ack. Separately, dirty_clr in the same cycle as a CPU-write ack -> dirty = 1.

Source files
------------

// File: rtl/cram_arb_pkg.sv
// ---------------------------------------------------------------------------
// cram_arb_pkg
// Shared definitions for the cartridge-RAM arbiter:
//   state_e      - access FSM states (idle, waiting on SRAM, ack/turnaround)
//   ID_*         - requester identifiers used for the winner and latched owner
//   STREAK_W     - width of the CPU starvation-guard streak counter
//   pick_byte()  - selects one byte lane of a 16-bit SRAM word
// ---------------------------------------------------------------------------
package cram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [1:0] ID_CPU = 2'd0;
    localparam logic [1:0] ID_SS  = 2'd1;
    localparam logic [1:0] ID_BK  = 2'd2;

    localparam int unsigned STREAK_W = 4;

    function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic hi);
        return hi ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/cram_arb_prio.sv
// ---------------------------------------------------------------------------
// cram_arb_prio
// Fixed-priority winner selection (CPU > SS > BK) with a CPU starvation guard.
// Ports:
//   clk_sys, reset          - system clock, synchronous active-high reset
//   cpu_req, ss_req, bk_req - live request lines
//   grant                   - strobe: the current winner is being granted
//   winner                  - combinational winner id (ID_CPU/ID_SS/ID_BK)
// ---------------------------------------------------------------------------
module cram_arb_prio
    import cram_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       ss_req,
    input  logic       bk_req,
    input  logic       grant,
    output logic [1:0] winner
);

    localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                other_req;
    logic                starved;

    assign other_req = ss_req | bk_req;
    // Once the CPU has won LIMIT times in a row over a waiting requester,
    // the next slot goes to that requester instead.
    assign starved   = other_req && (streak_q == LIMIT);

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        winner   = ID_CPU;
        streak_d = streak_q;

        if (cpu_req && !starved) begin
            winner = ID_CPU;
        end else if (ss_req) begin
            winner = ID_SS;
        end else if (bk_req) begin
            winner = ID_BK;
        end

        if (grant) begin
            if (winner == ID_CPU && other_req) begin
                streak_d = streak_q + STREAK_W'(1);
            end else begin
                streak_d = '0;
            end
        end
    end

    // NOTE: flops are written with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/cram_arbiter.sv
// ---------------------------------------------------------------------------
// cram_arbiter
// Shares the single cartridge-RAM SRAM port between the CPU, the savestate
// CRAM port and the backup load/save port. One access at a time, req/ack
// handshake on every side, all acks and mem_* outputs registered.
// Ports:
//   clk_sys, reset                  - system clock, synchronous active-high reset
//   cpu_* / ss_*                    - byte ports (17-bit byte address)
//   bk_*                            - word port (16-bit word address)
//   mem_req/we/ub/lb/addr/d         - request to the SRAM controller
//   mem_ack, mem_q                  - SRAM completion and read data
//   dirty, dirty_clr                - CPU-modified-save-RAM flag and its clear
// ---------------------------------------------------------------------------
module cram_arbiter
    import cram_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_sys,
    input  logic        reset,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [16:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,

    input  logic        ss_req,
    input  logic        ss_we,
    input  logic [16:0] ss_addr,
    input  logic [7:0]  ss_wdata,
    output logic        ss_ack,
    output logic [7:0]  ss_rdata,

    input  logic        bk_req,
    input  logic        bk_we,
    input  logic [15:0] bk_addr,
    input  logic [15:0] bk_wdata,
    output logic        bk_ack,
    output logic [15:0] bk_rdata,

    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_ub,
    output logic        mem_lb,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_d,
    input  logic        mem_ack,
    input  logic [15:0] mem_q,

    output logic        dirty,
    input  logic        dirty_clr
);

    state_e      state_q, state_d;
    logic [1:0]  id_q, id_d;
    logic        lane_q, lane_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic        mem_ub_q, mem_ub_d;
    logic        mem_lb_q, mem_lb_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_d_q, mem_d_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic        ss_ack_q, ss_ack_d;
    logic        bk_ack_q, bk_ack_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d;
    logic [7:0]  ss_rdata_q, ss_rdata_d;
    logic [15:0] bk_rdata_q, bk_rdata_d;
    logic        dirty_q, dirty_d;

    logic [1:0]  winner;
    logic        grant;
    logic        any_req;

    // Byte-port fields of whichever byte requester is winning.
    logic        byte_we;
    logic [16:0] byte_addr;
    logic [7:0]  byte_wdata;

    assign any_req    = cpu_req | ss_req | bk_req;
    assign byte_we    = (winner == ID_SS) ? ss_we    : cpu_we;
    assign byte_addr  = (winner == ID_SS) ? ss_addr  : cpu_addr;
    assign byte_wdata = (winner == ID_SS) ? ss_wdata : cpu_wdata;

    cram_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk_sys (clk_sys),
        .reset   (reset),
        .cpu_req (cpu_req),
        .ss_req  (ss_req),
        .bk_req  (bk_req),
        .grant   (grant),
        .winner  (winner)
    );

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        lane_d      = lane_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_ub_d    = mem_ub_q;
        mem_lb_d    = mem_lb_q;
        mem_addr_d  = mem_addr_q;
        mem_d_d     = mem_d_q;
        cpu_ack_d   = 1'b0;
        ss_ack_d    = 1'b0;
        bk_ack_d    = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        ss_rdata_d  = ss_rdata_q;
        bk_rdata_d  = bk_rdata_q;
        grant       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant     = 1'b1;
                    id_d      = winner;
                    mem_req_d = 1'b1;
                    state_d   = ST_WAIT;
                    if (winner == ID_BK) begin
                        mem_we_d   = bk_we;
                        mem_ub_d   = 1'b1;
                        mem_lb_d   = 1'b1;
                        mem_addr_d = bk_addr;
                        mem_d_d    = bk_wdata;
                        lane_d     = 1'b0;
                    end else begin
                        // Writes touch only the addressed lane; reads fetch the
                        // whole word and the lane is picked when data returns.
                        mem_we_d   = byte_we;
                        mem_ub_d   = ~byte_we | byte_addr[0];
                        mem_lb_d   = ~byte_we | ~byte_addr[0];
                        mem_addr_d = byte_addr[16:1];
                        mem_d_d    = {byte_wdata, byte_wdata};
                        lane_d     = byte_addr[0];
                    end
                end
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_DONE;
                    case (id_q)
                        ID_CPU: begin
                            cpu_ack_d = 1'b1;
                            if (!mem_we_q) cpu_rdata_d = pick_byte(mem_q, lane_q);
                        end
                        ID_SS: begin
                            ss_ack_d = 1'b1;
                            if (!mem_we_q) ss_rdata_d = pick_byte(mem_q, lane_q);
                        end
                        default: begin
                            bk_ack_d = 1'b1;
                            if (!mem_we_q) bk_rdata_d = mem_q;
                        end
                    endcase
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The owner latch and mem_we stay valid through DONE, so a CPU-write ack
    // is recognisable in the ack cycle itself. A coinciding clear loses.
    assign dirty_d = (cpu_ack_q & mem_we_q) | (dirty_q & ~dirty_clr);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            id_q        <= ID_CPU;
            lane_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_ub_q    <= 1'b0;
            mem_lb_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_d_q     <= '0;
            cpu_ack_q   <= 1'b0;
            ss_ack_q    <= 1'b0;
            bk_ack_q    <= 1'b0;
            cpu_rdata_q <= '0;
            ss_rdata_q  <= '0;
            bk_rdata_q  <= '0;
            dirty_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            lane_q      <= lane_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_ub_q    <= mem_ub_d;
            mem_lb_q    <= mem_lb_d;
            mem_addr_q  <= mem_addr_d;
            mem_d_q     <= mem_d_d;
            cpu_ack_q   <= cpu_ack_d;
            ss_ack_q    <= ss_ack_d;
            bk_ack_q    <= bk_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            ss_rdata_q  <= ss_rdata_d;
            bk_rdata_q  <= bk_rdata_d;
            dirty_q     <= dirty_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_ub    = mem_ub_q;
    assign mem_lb    = mem_lb_q;
    assign mem_addr  = mem_addr_q;
    assign mem_d     = mem_d_q;
    assign cpu_ack   = cpu_ack_q;
    assign ss_ack    = ss_ack_q;
    assign bk_ack    = bk_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ss_rdata  = ss_rdata_q;
    assign bk_rdata  = bk_rdata_q;
    assign dirty     = dirty_q;

endmodule

// File: tb/tb_cram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cram_arbiter
// Self-checking bench for cram_arbiter: directed scenarios plus randomized
// traffic against a byte-addressed reference memory and a dirty-flag model.
// Inputs are driven 1 time unit after each rising edge; outputs are read there.
// ---------------------------------------------------------------------------
module tb_cram_arbiter;

    localparam int LIMIT = 4;
    localparam int P_CPU = 0;
    localparam int P_SS  = 1;
    localparam int P_BK  = 2;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [16:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        ss_req = 1'b0, ss_we = 1'b0;
    logic [16:0] ss_addr = '0;
    logic [7:0]  ss_wdata = '0;
    logic        ss_ack;
    logic [7:0]  ss_rdata;
    logic        bk_req = 1'b0, bk_we = 1'b0;
    logic [15:0] bk_addr = '0;
    logic [15:0] bk_wdata = '0;
    logic        bk_ack;
    logic [15:0] bk_rdata;
    logic        mem_req, mem_we, mem_ub, mem_lb;
    logic [15:0] mem_addr, mem_d;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_q = '0;
    logic        dirty;
    logic        dirty_clr = 1'b0;

    cram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .ss_req    (ss_req),
        .ss_we     (ss_we),
        .ss_addr   (ss_addr),
        .ss_wdata  (ss_wdata),
        .ss_ack    (ss_ack),
        .ss_rdata  (ss_rdata),
        .bk_req    (bk_req),
        .bk_we     (bk_we),
        .bk_addr   (bk_addr),
        .bk_wdata  (bk_wdata),
        .bk_ack    (bk_ack),
        .bk_rdata  (bk_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_ub    (mem_ub),
        .mem_lb    (mem_lb),
        .mem_addr  (mem_addr),
        .mem_d     (mem_d),
        .mem_ack   (mem_ack),
        .mem_q     (mem_q),
        .dirty     (dirty),
        .dirty_clr (dirty_clr)
    );

    always #5 clk_sys = ~clk_sys;

    int n_cmp = 0;
    int n_err = 0;

    // SRAM responder state
    logic [15:0] sram [0:65535];
    int          sram_cnt = 0;
    int          sram_lat = 0;
    bit          sram_done = 1'b0;
    bit          sram_lat_rand = 1'b0;

    // Reference byte memory for the random test (bytes 0..31 = words 0..15)
    logic [7:0]  ref_b [0:31];

    // Advance one clock, then play the SRAM for the new cycle.
    task automatic step();
        @(posedge clk_sys);
        #1;
        if (mem_req && !sram_done) begin
            if (sram_cnt == 0) begin
                mem_ack   = 1'b1;
                sram_done = 1'b1;
                if (mem_we) begin
                    if (mem_ub) sram[mem_addr][15:8] = mem_d[15:8];
                    if (mem_lb) sram[mem_addr][7:0]  = mem_d[7:0];
                    mem_q = 16'($urandom);
                end else begin
                    mem_q = sram[mem_addr];
                end
            end else begin
                sram_cnt--;
                mem_ack = 1'b0;
                mem_q   = 16'($urandom);
            end
        end else begin
            mem_ack = 1'b0;
            mem_q   = 16'($urandom);
            if (!mem_req) begin
                sram_done = 1'b0;
                sram_cnt  = sram_lat_rand ? int'($urandom_range(0, 3)) : sram_lat;
            end
        end
    endtask

    task automatic set_req(input int p, input bit we, input logic [16:0] addr,
                           input logic [15:0] wdata);
        case (p)
            P_CPU: begin cpu_we = we; cpu_addr = addr; cpu_wdata = wdata[7:0]; cpu_req = 1'b1; end
            P_SS:  begin ss_we = we; ss_addr = addr; ss_wdata = wdata[7:0]; ss_req = 1'b1; end
            default: begin bk_we = we; bk_addr = addr[15:0]; bk_wdata = wdata; bk_req = 1'b1; end
        endcase
    endtask

    task automatic drop_req(input int p);
        case (p)
            P_CPU:   cpu_req = 1'b0;
            P_SS:    ss_req  = 1'b0;
            default: bk_req  = 1'b0;
        endcase
    endtask

    function automatic logic ack_of(input int p);
        case (p)
            P_CPU:   return cpu_ack;
            P_SS:    return ss_ack;
            default: return bk_ack;
        endcase
    endfunction

    function automatic logic [15:0] rdata_of(input int p);
        case (p)
            P_CPU:   return {8'h00, cpu_rdata};
            P_SS:    return {8'h00, ss_rdata};
            default: return bk_rdata;
        endcase
    endfunction

    // Drive one access and wait (bounded) for its ack; returns in the ack cycle.
    task automatic single_access(input int p, input bit we, input logic [16:0] addr,
                                 input logic [15:0] wdata, output bit got);
        got = 1'b0;
        set_req(p, we, addr, wdata);
        for (int i = 0; i < 60; i++) begin
            step();
            if (ack_of(p)) begin
                got = 1'b1;
                break;
            end
        end
        drop_req(p);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_cmp++;
        if ({mem_req, mem_we, mem_ub, mem_lb, mem_addr, mem_d, cpu_ack, ss_ack, bk_ack,
             cpu_rdata, ss_rdata, bk_rdata} !== 71'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h required 0",
                     {mem_req, mem_we, mem_ub, mem_lb, mem_addr, mem_d, cpu_ack, ss_ack, bk_ack,
                      cpu_rdata, ss_rdata, bk_rdata});
        end
        n_cmp++;
        if (dirty !== 1'b0) begin
            n_err++;
            $display("FAIL reset_dirty: got %b required 0", dirty);
        end
        reset = 1'b0;
        step();
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle_mem_req: got %b required 0", mem_req);
        end
    endtask

    task automatic test_cpu_write();
        sram_lat = 2;
        sram_lat_rand = 1'b0;
        step();
        set_req(P_CPU, 1'b1, 17'h00005, 16'h00A5);   // cycle 0
        for (int c = 1; c <= 6; c++) begin
            step();
            n_cmp++;
            if (mem_req !== (c >= 1 && c <= 3)) begin
                n_err++;
                $display("FAIL cpu_wr_mem_req c%0d: got %b required %b", c, mem_req, (c >= 1 && c <= 3));
            end
            if (c == 1) begin
                n_cmp++;
                if ({mem_we, mem_ub, mem_lb, mem_addr, mem_d} !== {1'b1, 1'b1, 1'b0, 16'h0002, 16'hA5A5}) begin
                    n_err++;
                    $display("FAIL cpu_wr_mem_fields: got we=%b ub=%b lb=%b addr=%h d=%h required we=1 ub=1 lb=0 addr=0002 d=a5a5",
                             mem_we, mem_ub, mem_lb, mem_addr, mem_d);
                end
            end
            n_cmp++;
            if (cpu_ack !== (c == 4)) begin
                n_err++;
                $display("FAIL cpu_wr_ack c%0d: got %b required %b", c, cpu_ack, (c == 4));
            end
            if (cpu_ack) drop_req(P_CPU);
            if (c == 4 || c == 5) begin
                n_cmp++;
                if (dirty !== (c == 5)) begin
                    n_err++;
                    $display("FAIL cpu_wr_dirty c%0d: got %b required %b", c, dirty, (c == 5));
                end
            end
        end
        drop_req(P_CPU);
    endtask

    task automatic test_ss_read();
        bit got;
        sram_lat = 1;
        step();
        sram[16'h0002] = 16'h1234;
        single_access(P_SS, 1'b0, 17'h00004, 16'h0000, got);
        n_cmp++;
        if (!got || ss_rdata !== 8'h34) begin
            n_err++;
            $display("FAIL ss_rd_lo: got ack=%b data=%h required ack=1 data=34", got, ss_rdata);
        end
        step();
        step();
        n_cmp++;
        if (ss_rdata !== 8'h34) begin
            n_err++;
            $display("FAIL ss_rd_hold: got %h required 34", ss_rdata);
        end
        single_access(P_SS, 1'b0, 17'h00005, 16'h0000, got);
        n_cmp++;
        if (!got || ss_rdata !== 8'h12) begin
            n_err++;
            $display("FAIL ss_rd_hi: got ack=%b data=%h required ack=1 data=12", got, ss_rdata);
        end
        step();
    endtask

    task automatic test_starvation();
        int order[$];
        int exp_order[$];
        sram_lat = 0;
        step();
        for (int i = 0; i < LIMIT; i++) exp_order.push_back(P_CPU);
        exp_order.push_back(P_BK);
        exp_order.push_back(P_CPU);
        exp_order.push_back(P_CPU);
        set_req(P_CPU, 1'b0, 17'h00010, 16'h0000);
        set_req(P_BK, 1'b0, 17'h00007, 16'h0000);
        for (int i = 0; i < 200 && order.size() < exp_order.size(); i++) begin
            step();
            if (cpu_ack) order.push_back(P_CPU);
            if (ss_ack)  order.push_back(P_SS);
            if (bk_ack) begin
                order.push_back(P_BK);
                drop_req(P_BK);
            end
        end
        drop_req(P_CPU);
        drop_req(P_BK);
        for (int i = 0; i < 6; i++) step();
        n_cmp++;
        if (order.size() != exp_order.size()) begin
            n_err++;
            $display("FAIL starve_count: got %0d grants required %0d", order.size(), exp_order.size());
        end
        for (int i = 0; i < exp_order.size() && i < order.size(); i++) begin
            n_cmp++;
            if (order[i] != exp_order[i]) begin
                n_err++;
                $display("FAIL starve_order[%0d]: got id %0d required id %0d", i, order[i], exp_order[i]);
            end
        end
    endtask

    task automatic test_collision();
        int order[$];
        int n_ack[3];
        logic [15:0] bk_exp;
        logic [15:0] bk_seen;
        logic [7:0]  ss_seen;
        sram_lat = 1;
        step();
        bk_exp = 16'($urandom);
        sram[16'h0030] = bk_exp;
        sram[16'h0010] = 16'h5A3C;
        n_ack = '{0, 0, 0};
        bk_seen = '0;
        ss_seen = '0;
        set_req(P_CPU, 1'b1, 17'h00040, 16'h0066);
        set_req(P_SS, 1'b0, 17'h00021, 16'h0000);
        set_req(P_BK, 1'b0, 17'h00030, 16'h0000);
        for (int i = 0; i < 40; i++) begin
            step();
            for (int p = 0; p < 3; p++) begin
                if (ack_of(p)) begin
                    order.push_back(p);
                    n_ack[p]++;
                    if (p == P_BK) bk_seen = bk_rdata;
                    if (p == P_SS) ss_seen = ss_rdata;
                    drop_req(p);
                end
            end
        end
        for (int p = 0; p < 3; p++) begin
            n_cmp++;
            if (n_ack[p] != 1) begin
                n_err++;
                $display("FAIL collide_ack_count port%0d: got %0d required 1", p, n_ack[p]);
            end
        end
        for (int i = 0; i < 3 && i < order.size(); i++) begin
            n_cmp++;
            if (order[i] != i) begin
                n_err++;
                $display("FAIL collide_order[%0d]: got id %0d required id %0d", i, order[i], i);
            end
        end
        n_cmp++;
        if (bk_seen !== bk_exp) begin
            n_err++;
            $display("FAIL collide_bk_rdata: got %h required %h", bk_seen, bk_exp);
        end
        n_cmp++;
        if (ss_seen !== 8'h5A) begin
            n_err++;
            $display("FAIL collide_ss_rdata: got %h required 5a", ss_seen);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int acks;
        sram_lat = 20;
        step();
        set_req(P_CPU, 1'b0, 17'h00008, 16'h0000);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = mem_req;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL rstmid_start: got mem_req=0 required 1");
        end
        step();
        reset = 1'b1;
        drop_req(P_CPU);
        step();
        n_cmp++;
        if (mem_req !== 1'b0 || cpu_ack !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_abort: got mem_req=%b ack=%b required 0 0", mem_req, cpu_ack);
        end
        reset = 1'b0;
        acks = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (cpu_ack || ss_ack || bk_ack || mem_req) acks++;
        end
        n_cmp++;
        if (acks != 0) begin
            n_err++;
            $display("FAIL rstmid_quiet: got %0d active cycles required 0", acks);
        end
        n_cmp++;
        if (dirty !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_dirty: got %b required 0", dirty);
        end
    endtask

    task automatic test_dirty_collision();
        bit got;
        sram_lat = 0;
        step();
        got = 1'b0;
        set_req(P_CPU, 1'b1, 17'h00003, 16'h0077);
        for (int i = 0; i < 20; i++) begin
            step();
            if (cpu_ack) begin
                got = 1'b1;
                dirty_clr = 1'b1;
                break;
            end
        end
        drop_req(P_CPU);
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL dirty_coll_ack: got no ack required ack");
        end
        step();
        dirty_clr = 1'b0;
        n_cmp++;
        if (dirty !== 1'b1) begin
            n_err++;
            $display("FAIL dirty_set_wins: got %b required 1", dirty);
        end
        dirty_clr = 1'b1;
        step();
        dirty_clr = 1'b0;
        n_cmp++;
        if (dirty !== 1'b0) begin
            n_err++;
            $display("FAIL dirty_clear: got %b required 0", dirty);
        end
    endtask

    typedef struct {
        bit          active;
        bit          we;
        logic [16:0] addr;
        logic [15:0] wdata;
        int          age;
    } txn_t;

    task automatic test_random();
        txn_t        pend [3];
        bit          exp_dirty;
        bit          cpu_wr_done;
        bit          any_active;
        int          nack;
        int          cyc;
        logic [15:0] v;
        logic [15:0] exp_v;
        for (int p = 0; p < 3; p++) pend[p] = '{1'b0, 1'b0, 17'd0, 16'd0, 0};
        for (int w = 0; w < 16; w++) begin
            v = 16'($urandom);
            sram[w] = v;
            ref_b[2*w]   = v[7:0];
            ref_b[2*w+1] = v[15:8];
        end
        sram_lat_rand = 1'b1;
        dirty_clr = 1'b1;
        step();
        dirty_clr = 1'b0;
        exp_dirty = 1'b0;
        cyc = 0;
        any_active = 1'b0;
        while (cyc < 2000 && (cyc < 1200 || any_active)) begin
            step();
            n_cmp++;
            if (dirty !== exp_dirty) begin
                n_err++;
                $display("FAIL rnd_dirty cyc%0d: got %b required %b", cyc, dirty, exp_dirty);
            end
            nack = 0;
            if (cpu_ack) nack++;
            if (ss_ack)  nack++;
            if (bk_ack)  nack++;
            n_cmp++;
            if (nack > 1) begin
                n_err++;
                $display("FAIL rnd_one_ack cyc%0d: got %0d acks required at most 1", cyc, nack);
            end
            cpu_wr_done = 1'b0;
            for (int p = 0; p < 3; p++) begin
                if (ack_of(p)) begin
                    n_cmp++;
                    if (!pend[p].active) begin
                        n_err++;
                        $display("FAIL rnd_spurious_ack port%0d cyc%0d: got ack required none", p, cyc);
                    end else begin
                        if (pend[p].we) begin
                            if (p == P_BK) begin
                                ref_b[{pend[p].addr[3:0], 1'b1}] = pend[p].wdata[15:8];
                                ref_b[{pend[p].addr[3:0], 1'b0}] = pend[p].wdata[7:0];
                            end else begin
                                ref_b[pend[p].addr[4:0]] = pend[p].wdata[7:0];
                            end
                            if (p == P_CPU) cpu_wr_done = 1'b1;
                        end else begin
                            if (p == P_BK)
                                exp_v = {ref_b[{pend[p].addr[3:0], 1'b1}], ref_b[{pend[p].addr[3:0], 1'b0}]};
                            else
                                exp_v = {8'h00, ref_b[pend[p].addr[4:0]]};
                            n_cmp++;
                            if (rdata_of(p) !== exp_v) begin
                                n_err++;
                                $display("FAIL rnd_rdata port%0d addr %h cyc%0d: got %h required %h",
                                         p, pend[p].addr, cyc, rdata_of(p), exp_v);
                            end
                        end
                        pend[p].active = 1'b0;
                        drop_req(p);
                    end
                end else if (pend[p].active) begin
                    pend[p].age++;
                    if (pend[p].age > 400) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL rnd_timeout port%0d cyc%0d: got no ack required ack", p, cyc);
                        pend[p].active = 1'b0;
                        drop_req(p);
                    end
                end else if (cyc < 1200 && $urandom_range(0, 2) == 0) begin
                    pend[p].active = 1'b1;
                    pend[p].we     = 1'($urandom_range(0, 1));
                    pend[p].addr   = (p == P_BK) ? 17'($urandom_range(0, 15)) : 17'($urandom_range(0, 31));
                    pend[p].wdata  = 16'($urandom);
                    pend[p].age    = 0;
                    set_req(p, pend[p].we, pend[p].addr, pend[p].wdata);
                end
            end
            dirty_clr = ($urandom_range(0, 7) == 0);
            exp_dirty = cpu_wr_done ? 1'b1 : (dirty_clr ? 1'b0 : exp_dirty);
            any_active = pend[0].active | pend[1].active | pend[2].active;
            cyc++;
        end
        dirty_clr = 1'b0;
        for (int p = 0; p < 3; p++) begin
            n_cmp++;
            if (pend[p].active) begin
                n_err++;
                $display("FAIL rnd_drain port%0d: got pending required completed", p);
                drop_req(p);
            end
        end
        sram_lat_rand = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) sram[i] = 16'h0000;
        test_reset();
        test_cpu_write();
        test_ss_read();
        test_starvation();
        test_collision();
        test_reset_mid();
        test_dirty_collision();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
